// File: rtl/nn_axi_pkg.sv
// Shared constants for the NN accelerator AXI-Lite register block.
// Register indices are byte offsets >> 2, matched against addr[4:2].
package nn_axi_pkg;

    localparam logic [2:0] REG_WEIGHT   = 3'd0;  // 0x00 WO
    localparam logic [2:0] REG_BIAS     = 3'd1;  // 0x04 WO
    localparam logic [2:0] REG_RESULT   = 3'd2;  // 0x08 RO
    localparam logic [2:0] REG_LAYER    = 3'd3;  // 0x0C RW
    localparam logic [2:0] REG_NEURON   = 3'd4;  // 0x10 RW
    localparam logic [2:0] REG_STATUS   = 3'd5;  // 0x14 RO
    localparam logic [2:0] REG_SOFT_RST = 3'd6;  // 0x18 WO

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACK,
        W_RESP
    } wstate_e;

endpackage

// File: rtl/nn_axi_lite_slave_if.sv
// AXI4-Lite bus bundle; the slave modport is the register block's view.
interface nn_axi_lite_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/nn_axi_lite_slave.sv
// AXI4-Lite register block feeding weights/bias/config to the NN core and
// collecting its result with a sticky interrupt. Read and write run independently.
module nn_axi_lite_slave
    import nn_axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    nn_axi_lite_slave_if.slave s_axi,
    output logic [DATA_W-1:0] weight_data,
    output logic              weight_valid,
    output logic [DATA_W-1:0] bias_data,
    output logic              bias_valid,
    output logic [DATA_W-1:0] layer_num,
    output logic [DATA_W-1:0] neuron_num,
    output logic              soft_reset,
    input  logic [DATA_W-1:0] result_in,
    input  logic              result_valid,
    output logic              intr
);

    wstate_e           wstate_q, wstate_d;
    logic [DATA_W-1:0] weight_data_q, bias_data_q, layer_q, neuron_q, result_q;
    logic              weight_valid_q, bias_valid_q, soft_reset_q, intr_q;
    logic              arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q, rd_word, wmask;
    logic [2:0]        wr_idx, rd_idx;
    logic              wr_en, ar_hs;

    // Only addr[4:2] selects a register; the rest of the address aliases.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[ADDR_W-1:5], s_axi.awaddr[1:0],
                           s_axi.araddr[ADDR_W-1:5], s_axi.araddr[1:0]};

    assign wr_idx = s_axi.awaddr[4:2];
    assign rd_idx = s_axi.araddr[4:2];
    assign wr_en  = (wstate_q == W_ACK);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_W/8; b++) wmask[b*8 +: 8] = {8{s_axi.wstrb[b]}};
    end

    // Write channel: address and data are only taken together, one beat at a time.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) wstate_q <= W_IDLE;
        else                wstate_q <= wstate_d;
    end

    always_comb begin
        wstate_d      = wstate_q;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = RESP_OKAY;
        case (wstate_q)
            W_IDLE: if (s_axi.awvalid && s_axi.wvalid) wstate_d = W_ACK;
            W_ACK: begin
                s_axi.awready = 1'b1;
                s_axi.wready  = 1'b1;
                wstate_d      = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            weight_data_q  <= '0;
            bias_data_q    <= '0;
            layer_q        <= '0;
            neuron_q       <= '0;
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            soft_reset_q   <= 1'b0;
        end else begin
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            soft_reset_q   <= 1'b0;
            if (wr_en) begin
                case (wr_idx)
                    REG_WEIGHT: begin
                        weight_data_q  <= s_axi.wdata;
                        weight_valid_q <= 1'b1;
                    end
                    REG_BIAS: begin
                        bias_data_q  <= s_axi.wdata;
                        bias_valid_q <= 1'b1;
                    end
                    REG_LAYER:    layer_q  <= (layer_q  & ~wmask) | (s_axi.wdata & wmask);
                    REG_NEURON:   neuron_q <= (neuron_q & ~wmask) | (s_axi.wdata & wmask);
                    REG_SOFT_RST: soft_reset_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Read channel: arready is a one-cycle pulse, only while no response is pending.
    assign ar_hs = arready_q && s_axi.arvalid;

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_RESULT: rd_word = result_q;
            REG_LAYER:  rd_word = layer_q;
            REG_NEURON: rd_word = neuron_q;
            REG_STATUS: rd_word = {{(DATA_W-1){1'b0}}, intr_q};
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= s_axi.arvalid && !rvalid_q && !arready_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // A new result beats a concurrent RESULT read so no completion is lost.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            result_q <= '0;
            intr_q   <= 1'b0;
        end else if (result_valid) begin
            result_q <= result_in;
            intr_q   <= 1'b1;
        end else if (ar_hs && rd_idx == REG_RESULT) begin
            intr_q   <= 1'b0;
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;

    assign weight_data  = weight_data_q;
    assign weight_valid = weight_valid_q;
    assign bias_data    = bias_data_q;
    assign bias_valid   = bias_valid_q;
    assign layer_num    = layer_q;
    assign neuron_num   = neuron_q;
    assign soft_reset   = soft_reset_q;
    assign intr         = intr_q;

endmodule

// File: tb/tb_nn_axi_lite_slave.sv
// Self-checking bench for nn_axi_lite_slave: vector table plus hand sequences,
// with read data and write responses checked through expectation queues.
module tb_nn_axi_lite_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] weight_data, bias_data, layer_num, neuron_num;
    logic        weight_valid, bias_valid, soft_reset, intr;
    logic [31:0] result_in = '0;
    logic        result_valid = 1'b0;

    nn_axi_lite_slave_if #(.DATA_W(32), .ADDR_W(32)) axi ();

    nn_axi_lite_slave #(.DATA_W(32), .ADDR_W(32)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (axi),
        .weight_data   (weight_data),
        .weight_valid  (weight_valid),
        .bias_data     (bias_data),
        .bias_valid    (bias_valid),
        .layer_num     (layer_num),
        .neuron_num    (neuron_num),
        .soft_reset    (soft_reset),
        .result_in     (result_in),
        .result_valid  (result_valid),
        .intr          (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rq[$];
    logic [1:0]  bq[$];
    int          n_vec = 0, n_err = 0;

    // Output event monitors, sampled on the inactive edge.
    int          wv_cnt = 0, bv_cnt = 0, sr_cnt = 0, aw_cnt = 0, b_cnt = 0;
    logic [31:0] wd_seen = '0, bd_seen = '0;
    logic        bv_prev = 1'b0;
    always @(negedge clk) begin
        if (weight_valid) begin wv_cnt++; wd_seen = weight_data; end
        if (bias_valid)   begin bv_cnt++; bd_seen = bias_data; end
        if (soft_reset)   sr_cnt++;
        if (axi.awready)  aw_cnt++;
        if (axi.bvalid && !bv_prev) b_cnt++;
        bv_prev = axi.bvalid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int         cyc;
        logic [1:0] e;
        @(negedge clk);
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        bq.push_back(2'b00);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!axi.awready && cyc < 20);
        chk("aw_w_ready", {30'd0, axi.awready, axi.wready}, 32'd3);
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        chk("awready_one_cycle", {31'd0, axi.awready}, 32'd0);
        cyc = 0;
        while (!axi.bvalid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("bvalid", {31'd0, axi.bvalid}, 32'd1);
        e = bq.pop_front();
        chk("bresp", {30'd0, axi.bresp}, {30'd0, e});
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        chk("bvalid_clear", {31'd0, axi.bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] e);
        int          cyc;
        logic [31:0] x;
        @(negedge clk);
        axi.araddr = a; axi.arvalid = 1'b1;
        rq.push_back(e);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!axi.arready && cyc < 20);
        chk("arready", {31'd0, axi.arready}, 32'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        cyc = 0;
        while (!axi.rvalid && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rvalid", {31'd0, axi.rvalid}, 32'd1);
        x = rq.pop_front();
        chk($sformatf("rdata@%h", a), axi.rdata, x);
        chk("rresp", {30'd0, axi.rresp}, 32'd0);
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          a0, b0, w0, s0, cyc;
        logic [31:0] x;

        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

        vecs.push_back('{1'b1, 32'h0C, 32'h0000_0003, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0000_0003});
        vecs.push_back('{1'b0, 32'h00, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 32'h10, 32'hAABB_CCDD, 4'h3, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,         4'h0, 32'h0000_CCDD});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 32'h08, 32'h0000_0055, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 32'h2C, 32'h0000_0100, 4'h2, 32'h0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0000_0103});
        vecs.push_back('{1'b0, 32'h1C, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 32'h1C, 32'hDEAD_BEEF, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0,         4'h0, 32'h0000_CCDD});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0, 32'h0});

        // Reset state
        #3;
        chk("reset_flags", {23'd0, axi.awready, axi.wready, axi.bvalid, axi.arready,
                            axi.rvalid, weight_valid, bias_valid, soft_reset, intr}, 32'd0);
        chk("reset_layer", layer_num, 32'd0);
        chk("reset_neuron", neuron_num, 32'd0);
        chk("reset_rdata", axi.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else            axi_read(vecs[i].addr, vecs[i].exp);
            if (i == 0) chk("layer_num_after_first", layer_num, 32'd3);
        end
        chk("layer_num", layer_num, 32'h0000_0103);
        chk("neuron_num", neuron_num, 32'h0000_CCDD);

        // Core-side pulses: one cycle each, full data regardless of strobes
        w0 = wv_cnt;
        axi_write(32'h00, 32'h0000_1234, 4'hF);
        chk("weight_valid_pulses", wv_cnt - w0, 32'd1);
        chk("weight_data", wd_seen, 32'h0000_1234);
        axi_read(32'h00, 32'h0);
        w0 = bv_cnt;
        axi_write(32'h04, 32'h0000_BEEF, 4'h1);
        chk("bias_valid_pulses", bv_cnt - w0, 32'd1);
        chk("bias_data", bd_seen, 32'h0000_BEEF);
        s0 = sr_cnt;
        axi_write(32'h18, 32'h1, 4'h0);
        chk("soft_reset_pulses", sr_cnt - s0, 32'd1);

        // Address early: nothing accepted until write data shows up
        a0 = aw_cnt; b0 = b_cnt;
        @(negedge clk);
        axi.awaddr = 32'h0C; axi.awvalid = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_awready_without_wvalid", aw_cnt - a0, 32'd0);
        axi_write(32'h0C, 32'h0000_0005, 4'hF);
        chk("awready_cycles", aw_cnt - a0, 32'd1);
        chk("bvalid_responses", b_cnt - b0, 32'd1);
        chk("layer_after_late_w", layer_num, 32'd5);

        // Interrupt set/clear and same-cycle set-wins
        chk("intr_idle", {31'd0, intr}, 32'd0);
        @(negedge clk); result_in = 32'd7; result_valid = 1'b1;
        @(negedge clk); result_valid = 1'b0;
        chk("intr_set", {31'd0, intr}, 32'd1);
        axi_read(32'h14, 32'd1);
        axi_read(32'h08, 32'd7);
        chk("intr_cleared", {31'd0, intr}, 32'd0);
        @(negedge clk); result_in = 32'd9; result_valid = 1'b1;
        @(negedge clk); result_valid = 1'b0;
        axi.araddr = 32'h08; axi.arvalid = 1'b1;
        rq.push_back(32'd9);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!axi.arready && cyc < 20);
        chk("arready_race", {31'd0, axi.arready}, 32'd1);
        result_in = 32'd11; result_valid = 1'b1;
        @(negedge clk);
        axi.arvalid = 1'b0; result_valid = 1'b0;
        chk("rvalid_race", {31'd0, axi.rvalid}, 32'd1);
        x = rq.pop_front();
        chk("rdata_race", axi.rdata, x);
        chk("intr_set_wins", {31'd0, intr}, 32'd1);
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        axi_read(32'h08, 32'd11);
        chk("intr_cleared2", {31'd0, intr}, 32'd0);

        // Concurrent read and write
        fork
            axi_write(32'h10, 32'h1122_3344, 4'hF);
            axi_read(32'h0C, 32'd5);
        join
        axi_read(32'h10, 32'h1122_3344);

        // Stalled response, then reset mid-transaction
        @(negedge clk);
        axi.awaddr = 32'h00; axi.wdata = 32'h0000_FACE; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!axi.awready && cyc < 20);
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            if (axi.bvalid) cyc++;
            @(negedge clk);
        end
        chk("bvalid_held", cyc, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_flags", {23'd0, axi.awready, axi.wready, axi.bvalid, axi.arready,
                               axi.rvalid, weight_valid, bias_valid, soft_reset, intr}, 32'd0);
        chk("midreset_regs", layer_num | neuron_num | weight_data | bias_data | axi.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b0 = b_cnt;
        repeat (3) @(negedge clk);
        chk("no_resp_after_reset", b_cnt - b0, 32'd0);
        chk("read_queue_empty", rq.size(), 32'd0);
        chk("bresp_queue_empty", bq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
